// File: rtl/btn_event_gen.sv
// Turns a debounced button level into single-cycle press, release, long-press and auto-repeat events.
// Hold timing is measured in tick units, so one instance works at any clock rate.
module btn_event_gen #(
  parameter int CNT_W        = 16,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic tick,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  typedef enum logic [2:0] {
    ARM     = 3'd0,
    IDLE    = 3'd1,
    PRESSED = 3'd2,
    LONG    = 3'd3,
    BLOCKED = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;

  // Event FSM: state, hold counter and all pulse/level outputs are registered together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ARM;
      cnt_r         <= CNT_ZERO;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state_r)
        // A button already down when reset lifts must be released before it can count.
        ARM: begin
          held <= 1'b0;
          cnt_r <= CNT_ZERO;
          if (btn) begin
            state_r <= BLOCKED;
          end else begin
            state_r <= IDLE;
          end
        end
        BLOCKED: begin
          held <= 1'b0;
          cnt_r <= CNT_ZERO;
          if (!btn) begin
            state_r <= IDLE;
          end else begin
            state_r <= BLOCKED;
          end
        end
        IDLE: begin
          cnt_r <= CNT_ZERO;
          if (btn) begin
            state_r     <= PRESSED;
            press_pulse <= 1'b1;
            held        <= 1'b1;
          end else begin
            state_r <= IDLE;
            held    <= 1'b0;
          end
        end
        // Release is tested first so it always wins over a coincident long-press.
        PRESSED: begin
          if (!btn) begin
            state_r       <= IDLE;
            release_pulse <= 1'b1;
            held          <= 1'b0;
            cnt_r         <= CNT_ZERO;
          end else if (tick && (cnt_r == LONG_LAST)) begin
            state_r    <= LONG;
            long_press <= 1'b1;
            held       <= 1'b1;
            cnt_r      <= CNT_ZERO;
          end else if (tick) begin
            state_r <= PRESSED;
            held    <= 1'b1;
            cnt_r   <= cnt_r + CNT_ONE;
          end else begin
            state_r <= PRESSED;
            held    <= 1'b1;
          end
        end
        LONG: begin
          if (!btn) begin
            state_r       <= IDLE;
            release_pulse <= 1'b1;
            held          <= 1'b0;
            cnt_r         <= CNT_ZERO;
          end else if (REPEAT_EN && tick && (cnt_r == REPEAT_LAST)) begin
            state_r      <= LONG;
            repeat_pulse <= 1'b1;
            held         <= 1'b1;
            cnt_r        <= CNT_ZERO;
          end else if (REPEAT_EN && tick) begin
            state_r <= LONG;
            held    <= 1'b1;
            cnt_r   <= cnt_r + CNT_ONE;
          end else begin
            state_r <= LONG;
            held    <= 1'b1;
          end
        end
        default: begin
          state_r <= ARM;
          held    <= 1'b0;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event_gen.sv
// Scoreboard bench for btn_event_gen: two instances (auto-repeat on/off) share stimulus and are
// compared every cycle against a hold-time reference model.
module tb_btn_event_gen;

  localparam int LT = 4;
  localparam int RT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn = 1'b0;
  logic tick = 1'b0;

  logic p0, r0, l0, q0, h0;
  logic p1, r1, l1, q1, h1;

  int vecs = 0;
  int fails = 0;
  int seen_long = 0;
  int seen_rep = 0;

  // {dut1 vector, dut0 vector}, each {press, release, long, repeat, held}
  logic [9:0] exp_q[$];

  bit m_first[2];
  bit m_blocked[2];
  bit m_active[2];
  int m_hold[2];

  always #5 clk = ~clk;

  btn_event_gen #(.CNT_W(16), .LONG_TICKS(LT), .REPEAT_TICKS(RT), .REPEAT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .btn(btn), .tick(tick),
    .press_pulse(p0), .release_pulse(r0), .long_press(l0), .repeat_pulse(q0), .held(h0)
  );

  btn_event_gen #(.CNT_W(16), .LONG_TICKS(LT), .REPEAT_TICKS(RT), .REPEAT_EN(1'b0)) dut_norep (
    .clk(clk), .rst(rst), .btn(btn), .tick(tick),
    .press_pulse(p1), .release_pulse(r1), .long_press(l1), .repeat_pulse(q1), .held(h1)
  );

  // Reference: hold time is total ticks seen since the press edge; events are derived arithmetically.
  function automatic logic [4:0] model_step(int k, bit b, bit t, bit ren);
    logic pr, rl, lg, rp;
    pr = 1'b0; rl = 1'b0; lg = 1'b0; rp = 1'b0;
    if (m_first[k]) begin
      m_first[k] = 1'b0;
      m_blocked[k] = b;
    end else if (m_blocked[k]) begin
      if (!b) m_blocked[k] = 1'b0;
    end else if (!m_active[k]) begin
      if (b) begin
        m_active[k] = 1'b1;
        m_hold[k] = 0;
        pr = 1'b1;
      end
    end else if (!b) begin
      m_active[k] = 1'b0;
      rl = 1'b1;
    end else if (t) begin
      m_hold[k] = m_hold[k] + 1;
      if (m_hold[k] == LT) lg = 1'b1;
      else if (ren && m_hold[k] > LT && ((m_hold[k] - LT) % RT) == 0) rp = 1'b1;
    end
    return {pr, rl, lg, rp, m_active[k]};
  endfunction

  // Model advances on every rising edge and queues what the DUTs must show in the following cycle.
  always @(posedge clk) begin
    logic [4:0] e0, e1;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_first[k] = 1'b1; m_blocked[k] = 1'b0; m_active[k] = 1'b0; m_hold[k] = 0;
      end
      exp_q.push_back(10'd0);
    end else begin
      e0 = model_step(0, btn, tick, 1'b1);
      e1 = model_step(1, btn, tick, 1'b0);
      exp_q.push_back({e1, e0});
    end
  end

  // Monitor: compares registered outputs mid-cycle; while reset is held the expectation is all zero.
  always @(negedge clk) begin
    logic [9:0] e;
    logic [4:0] a0, a1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!rst) e = 10'd0;
      a0 = {p0, r0, l0, q0, h0};
      a1 = {p1, r1, l1, q1, h1};
      vecs++;
      if (a0 !== e[4:0]) begin
        fails++;
        $display("FAIL rep_on t=%0t got=%b want=%b", $time, a0, e[4:0]);
      end
      vecs++;
      if (a1 !== e[9:5]) begin
        fails++;
        $display("FAIL rep_off t=%0t got=%b want=%b", $time, a1, e[9:5]);
      end
      if (e[2]) seen_long++;
      if (e[1]) seen_rep++;
    end
  end

  task automatic drive(input bit b, input bit t);
    btn = b;
    tick = t;
    @(posedge clk);
    #2;
  endtask

  // Asserts reset between edges and checks the asynchronous clear before any edge arrives.
  task automatic do_reset(input bit b);
    rst = 1'b0;
    btn = b;
    tick = 1'b1;
    #1;
    vecs++;
    if ({p0, r0, l0, q0, h0, p1, r1, l1, q1, h1} !== 10'd0) begin
      fails++;
      $display("FAIL async_reset got=%b want=0", {p0, r0, l0, q0, h0, p1, r1, l1, q1, h1});
    end
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #2;
    do_reset(1'b0);
    // basic press / release
    repeat (3) drive(1'b0, 1'b1);
    repeat (2) drive(1'b1, 1'b1);
    repeat (3) drive(1'b0, 1'b1);
    // long press with repeats
    repeat (12) drive(1'b1, 1'b1);
    repeat (3) drive(1'b0, 1'b1);
    // held through reset: blocked until released
    do_reset(1'b1);
    repeat (10) drive(1'b1, 1'b1);
    repeat (2) drive(1'b0, 1'b1);
    repeat (2) drive(1'b1, 1'b1);
    repeat (2) drive(1'b0, 1'b1);
    // sparse ticks, one coincident with the press edge
    for (int i = 0; i < 20; i++) drive(1'b1, (i % 3) == 0);
    repeat (2) drive(1'b0, 1'b0);
    // release on the edge that would have fired long_press
    repeat (4) drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    repeat (2) drive(1'b0, 1'b1);
    // back-to-back 1,0,1
    drive(1'b1, 1'b0); drive(1'b0, 1'b0); drive(1'b1, 1'b0); drive(1'b0, 1'b0);
    // reset during repeat, then a normal press
    repeat (9) drive(1'b1, 1'b1);
    do_reset(1'b0);
    drive(1'b0, 1'b1);
    repeat (3) drive(1'b1, 1'b1);
    repeat (2) drive(1'b0, 1'b1);
    // randomized phase
    for (int i = 0; i < 1500; i++) begin
      bit b;
      b = btn;
      if ($urandom_range(5, 0) == 0) b = ~b;
      if ($urandom_range(299, 0) == 0) do_reset(b);
      else drive(b, $urandom_range(1, 0) == 1);
    end
    repeat (3) drive(1'b0, 1'b0);
    vecs++;
    if (seen_long == 0 || seen_rep == 0) begin
      fails++;
      $display("FAIL coverage long=%0d repeat=%0d want both nonzero", seen_long, seen_rep);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/btn_event_gen.md
Name: btn_event_gen

Overview:
- Consumes the debounced, synchronised level of one pushbutton and converts it into single-cycle control events: press, release, long-press and auto-repeat.
- Sits directly downstream of the per-button debouncer.
- Feeds the control FSM, which acts on pulses, not levels.
- Hold timing is counted in `tick` units (prescaled enable), so one block serves any clock rate.

Parameters:
- CNT_W, 16, width of the hold/repeat counter.
- LONG_TICKS, 1000, ticks of continuous hold before `long_press`; legal range 1..2^CNT_W-1.
- REPEAT_TICKS, 200, ticks between `repeat_pulse` events after `long_press`; legal range 1..2^CNT_W-1.
- REPEAT_EN, 1, 1 enables auto-repeat; 0 means no `repeat_pulse` ever.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- btn  input  1  debounced button level, already synchronous to `clk`.
- tick  input  1  one-cycle timebase enable; counters advance only when high.
- press_pulse  output  1  one cycle high on each accepted press.
- release_pulse  output  1  one cycle high on release of an accepted press.
- long_press  output  1  one cycle high when hold reaches LONG_TICKS.
- repeat_pulse  output  1  one cycle high every REPEAT_TICKS while held past long-press.
- held  output  1  level: an accepted press is in progress (states PRESSED, LONG).

Behaviour:
- Outputs:
  - All outputs are registered.
  - While `rst`=0: all outputs 0, counter 0, state ARM, `btn` sample register 0.
- States: ARM, IDLE, PRESSED, LONG, BLOCKED.
- ARM (first edge after reset release):
  - Samples `btn`.
  - `btn`=1 goes to BLOCKED; `btn`=0 goes to IDLE.
  - No event is ever generated in ARM, so a button held through reset produces no press.
- BLOCKED:
  - Waits for `btn`=0, then goes to IDLE.
  - No pulses are generated, including no `release_pulse`.
- IDLE:
  - `btn`=1 goes to PRESSED, clears the counter, and raises `press_pulse` for the following cycle.
  - Latency: `press_pulse` is high in the cycle after the edge at which `btn` is first sampled 1.
  - `tick` is ignored in IDLE.
- PRESSED:
  - If `btn`=0: go to IDLE, pulse `release_pulse`, clear the counter.
  - Else if `tick`=1 and counter==LONG_TICKS-1: go to LONG, pulse `long_press`, clear the counter.
  - Else if `tick`=1: increment the counter.
  - Counting starts on the first edge after entering PRESSED.
  - A `tick` coincident with the press edge is not counted.
- LONG:
  - If `btn`=0: go to IDLE, pulse `release_pulse`, clear the counter.
  - Else if REPEAT_EN and `tick`=1 and counter==REPEAT_TICKS-1: pulse `repeat_pulse`, clear the counter.
  - Else if REPEAT_EN and `tick`=1: increment the counter.
  - The counter wraps to 0 only through the clear; it never overflows.
- Simultaneous events:
  - Release has priority over `long_press` or `repeat_pulse` on the same edge; only `release_pulse` fires.
  - At most one of the four pulse outputs is high in any cycle.
- `held` is high exactly while the state is PRESSED or LONG (registered, same cycle as the state).
- Reset mid-operation: on `rst` assertion, all outputs clear asynchronously. No `release_pulse` is generated for the aborted press.
- Back-to-back:
  - `btn` 1,0,1 on consecutive edges gives `press_pulse`, `release_pulse`, `press_pulse` in consecutive cycles.
  - The block does not filter glitches; that is upstream's job.

Test Plan:
Parameters for all scenarios: LONG_TICKS=4, REPEAT_TICKS=2, REPEAT_EN=1, CNT_W=16, `tick` tied 1 unless stated.
1. Reset, then `btn` low→high at edge k, held 2 cycles, then low → `press_pulse` high cycle k+1 only; `release_pulse` high the cycle after `btn` is sampled 0; `long_press`, `repeat_pulse` never high.
2. `btn` high from edge k, held 12 cycles → `press_pulse` at k+1; `long_press` at k+5 (4 cycles later); `repeat_pulse` at k+7, k+9, k+11; `held`=1 throughout; a single `release_pulse` after drop.
3. `btn` held high through `rst` deassert for 10 cycles, then low, then high → no pulses until the second rising level; then `press_pulse` once.
4. `tick` pulsed every 3rd cycle, `btn` held → `long_press` after exactly 4 ticks counted from the edge after press; ticks coincident with the press edge are not counted.
5. `btn` drops on the same edge the counter reaches LONG_TICKS-1 with `tick`=1 → `release_pulse` only, no `long_press`; state IDLE.
6. `rst` asserted in LONG mid-repeat → all outputs 0 immediately; after deassert with `btn`=0, the next press gives a normal `press_pulse`. Repeat scenario 2 with REPEAT_EN=0 → `long_press` once, no `repeat_pulse`.
